// File: rtl/spmv_cplx_pp.sv
// Complex sparse-row x dense-vector engine with ping-pong vector banks.
// Four-register pipeline after row accept: RAM/coeff capture, lane products, lane sum, scale/saturate.
module spmv_cplx_pp #(
   parameter int MAT_RANK = 256,
   parameter int NNZ      = 4,
   parameter int DW       = 32,
   parameter int FRAC     = 16,
   localparam int AW      = $clog2(MAT_RANK)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DW-1:0]       src_r,
   input  logic [DW-1:0]       src_i,
   input  logic                src_vld,
   output logic                src_rdy,
   input  logic [NNZ*AW-1:0]   S_col,
   input  logic [NNZ*DW-1:0]   S_val_r,
   input  logic [NNZ*DW-1:0]   S_val_i,
   input  logic [NNZ-1:0]      S_mask,
   input  logic                S_last,
   input  logic                S_vld,
   output logic                S_rdy,
   output logic [DW-1:0]       spmv_r,
   output logic [DW-1:0]       spmv_i,
   output logic                spmv_vld,
   input  logic                spmv_rdy,
   output logic                idx_err,
   output logic                busy
);

   localparam int PW = 2*DW + 1;
   localparam int SW = PW + $clog2(NNZ);
   localparam logic [AW:0]   RANK_W = (AW+1)'(MAT_RANK);
   localparam logic [AW-1:0] LAST_A = AW'(MAT_RANK - 1);

   logic [2*DW-1:0]      mem_q [2][NNZ][MAT_RANK];
   logic [2*DW-1:0]      rd_q  [NNZ];

   logic [1:0]           full_q, full_d;
   logic                 wbank_q, rbank_q;
   logic [AW-1:0]        waddr_q;
   logic                 va_q, vb_q, vc_q, vo_q;
   logic [DW-1:0]        cr_q [NNZ];
   logic [DW-1:0]        ci_q [NNZ];
   logic [NNZ-1:0]       ok_q, ok_d;
   logic signed [PW-1:0] pr_q [NNZ];
   logic signed [PW-1:0] pi_q [NNZ];
   logic signed [PW-1:0] pr_d [NNZ];
   logic signed [PW-1:0] pi_d [NNZ];
   logic signed [SW-1:0] sr_q, si_q, sr_d, si_d;
   logic [DW-1:0]        out_r_q, out_i_q;
   logic                 idx_err_q;

   logic [AW-1:0]        col_w [NNZ];
   logic [AW-1:0]        raddr [NNZ];
   logic [NNZ-1:0]       in_rng;
   logic                 bad_col;
   logic                 stall, wr, acc, wr_last;

   function automatic logic signed [2*DW-1:0] mul(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
      return (2*DW)'(a) * (2*DW)'(b);
   endfunction

   function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] v);
      logic signed [SW-1:0] hi, lo;
      hi = SW'({1'b0, {(DW-1){1'b1}}});
      lo = ~hi;
      if (v > hi)      return hi[DW-1:0];
      else if (v < lo) return lo[DW-1:0];
      else             return v[DW-1:0];
   endfunction

   assign stall   = vo_q && !spmv_rdy;
   assign src_rdy = !full_q[wbank_q];
   assign wr      = src_vld && src_rdy;
   assign wr_last = wr && (waddr_q == LAST_A);
   assign S_rdy   = full_q[rbank_q] && !stall;
   assign acc     = S_vld && S_rdy;

   // Out-of-range lanes read address 0 and are zeroed later through ok_q.
   always_comb begin
      bad_col = 1'b0;
      for (int k = 0; k < NNZ; k++) begin
         col_w[k]  = S_col[k*AW +: AW];
         in_rng[k] = {1'b0, col_w[k]} < RANK_W;
         raddr[k]  = in_rng[k] ? col_w[k] : '0;
         ok_d[k]   = S_mask[k] && in_rng[k];
         bad_col   = bad_col | (S_mask[k] && !in_rng[k]);
      end
   end

   always_comb begin
      full_d = full_q;
      if (wr_last)        full_d[wbank_q] = 1'b1;
      if (acc && S_last)  full_d[rbank_q] = 1'b0;
   end

   always_comb begin
      for (int k = 0; k < NNZ; k++) begin
         pr_d[k] = '0;
         pi_d[k] = '0;
         if (ok_q[k]) begin
            pr_d[k] = PW'(mul(cr_q[k], rd_q[k][2*DW-1:DW])) - PW'(mul(ci_q[k], rd_q[k][DW-1:0]));
            pi_d[k] = PW'(mul(cr_q[k], rd_q[k][DW-1:0]))    + PW'(mul(ci_q[k], rd_q[k][2*DW-1:DW]));
         end
      end
   end

   always_comb begin
      sr_d = '0;
      si_d = '0;
      for (int k = 0; k < NNZ; k++) begin
         sr_d = sr_d + SW'(pr_q[k]);
         si_d = si_d + SW'(pi_q[k]);
      end
   end

   // Replicated lane RAMs share the write port; reads fire only on an accepted row.
   always_ff @(posedge clk) begin
      if (wr) begin
         for (int k = 0; k < NNZ; k++) mem_q[wbank_q][k][waddr_q] <= {src_r, src_i};
      end
      if (acc) begin
         for (int k = 0; k < NNZ; k++) rd_q[k] <= mem_q[rbank_q][k][raddr[k]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q    <= '0;
         wbank_q   <= 1'b0;
         rbank_q   <= 1'b0;
         waddr_q   <= '0;
         va_q      <= 1'b0;
         vb_q      <= 1'b0;
         vc_q      <= 1'b0;
         vo_q      <= 1'b0;
         ok_q      <= '0;
         sr_q      <= '0;
         si_q      <= '0;
         out_r_q   <= '0;
         out_i_q   <= '0;
         idx_err_q <= 1'b0;
         for (int k = 0; k < NNZ; k++) begin
            cr_q[k] <= '0;
            ci_q[k] <= '0;
            pr_q[k] <= '0;
            pi_q[k] <= '0;
         end
      end else begin
         full_q <= full_d;
         if (wr) begin
            if (wr_last) begin
               waddr_q <= '0;
               wbank_q <= !wbank_q;
            end else begin
               waddr_q <= waddr_q + AW'(1);
            end
         end
         if (acc && S_last) rbank_q <= !rbank_q;
         if (acc && bad_col) idx_err_q <= 1'b1;
         if (!stall) begin
            va_q <= acc;
            if (acc) begin
               ok_q <= ok_d;
               for (int k = 0; k < NNZ; k++) begin
                  cr_q[k] <= S_val_r[k*DW +: DW];
                  ci_q[k] <= S_val_i[k*DW +: DW];
               end
            end
            vb_q <= va_q;
            for (int k = 0; k < NNZ; k++) begin
               pr_q[k] <= pr_d[k];
               pi_q[k] <= pi_d[k];
            end
            vc_q <= vb_q;
            sr_q <= sr_d;
            si_q <= si_d;
            vo_q <= vc_q;
            if (vc_q) begin
               out_r_q <= sat(sr_q >>> FRAC);
               out_i_q <= sat(si_q >>> FRAC);
            end
         end
      end
   end

   assign spmv_r   = out_r_q;
   assign spmv_i   = out_i_q;
   assign spmv_vld = vo_q;
   assign idx_err  = idx_err_q;
   assign busy     = (|full_q) | va_q | vb_q | vc_q | vo_q;

endmodule

// File: tb/tb_spmv_cplx_pp.sv
// Directed + randomized bench for spmv_cplx_pp with an arithmetic reference model.
// MAT_RANK=6 so that out-of-range column indices fit in the 3-bit index field.
module tb_spmv_cplx_pp;
   localparam int MR   = 6;
   localparam int NZ   = 4;
   localparam int DW   = 32;
   localparam int FRAC = 16;
   localparam int AW   = $clog2(MR);

   typedef struct {
      logic [31:0] r [MR];
      logic [31:0] i [MR];
   } vec_t;

   typedef struct {
      int          col [NZ];
      logic [31:0] vr  [NZ];
      logic [31:0] vi  [NZ];
      logic [3:0]  mask;
      bit          last;
   } row_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [DW-1:0]    src_r = '0, src_i = '0;
   logic             src_vld = 1'b0, src_rdy;
   logic [NZ*AW-1:0] S_col = '0;
   logic [NZ*DW-1:0] S_val_r = '0, S_val_i = '0;
   logic [NZ-1:0]    S_mask = '0;
   logic             S_last = 1'b0, S_vld = 1'b0, S_rdy;
   logic [DW-1:0]    spmv_r, spmv_i;
   logic             spmv_vld, spmv_rdy = 1'b1;
   logic             idx_err, busy;

   int   n_pass = 0, n_tot = 0, n_fail = 0;
   bit   a_last_done = 1'b0;
   vec_t vecq [$];
   logic [63:0] exp_q [$];
   logic [63:0] obs_q [$];

   always #5 clk = ~clk;

   spmv_cplx_pp #(.MAT_RANK(MR), .NNZ(NZ), .DW(DW), .FRAC(FRAC)) dut (
      .clk(clk), .rst(rst),
      .src_r(src_r), .src_i(src_i), .src_vld(src_vld), .src_rdy(src_rdy),
      .S_col(S_col), .S_val_r(S_val_r), .S_val_i(S_val_i), .S_mask(S_mask),
      .S_last(S_last), .S_vld(S_vld), .S_rdy(S_rdy),
      .spmv_r(spmv_r), .spmv_i(spmv_i), .spmv_vld(spmv_vld), .spmv_rdy(spmv_rdy),
      .idx_err(idx_err), .busy(busy)
   );

   always @(negedge clk) begin
      if (!rst && spmv_vld && spmv_rdy) obs_q.push_back({spmv_r, spmv_i});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rnd_val();
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 3) != 0) v = 32'($signed(v[19:0]));
      return v;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      for (int s = 0; s < MR; s++) begin
         v.r[s] = rnd_val();
         v.i[s] = rnd_val();
      end
      return v;
   endfunction

   function automatic row_t gen_row(input bit last);
      row_t r;
      for (int k = 0; k < NZ; k++) begin
         r.col[k] = $urandom_range(0, MR-1);
         r.vr[k]  = rnd_val();
         r.vi[k]  = rnd_val();
      end
      r.mask = 4'($urandom_range(1, 15));
      r.last = last;
      return r;
   endfunction

   function automatic logic [31:0] sat_ref(input logic signed [127:0] v);
      logic signed [127:0] hi, lo;
      hi = 128'sd2147483647;
      lo = -128'sd2147483648;
      if (v > hi)      return 32'h7FFF_FFFF;
      else if (v < lo) return 32'h8000_0000;
      else             return v[31:0];
   endfunction

   // Complex dot product of the enabled, in-range lanes, Q16 rescale, saturate.
   function automatic logic [63:0] ref_row(input row_t r, input vec_t x);
      logic signed [127:0] ar, ai, vr, vi, xr, xi;
      ar = '0;
      ai = '0;
      for (int k = 0; k < NZ; k++) begin
         if (r.mask[k] && r.col[k] < MR) begin
            vr = 128'($signed(r.vr[k]));
            vi = 128'($signed(r.vi[k]));
            xr = 128'($signed(x.r[r.col[k]]));
            xi = 128'($signed(x.i[r.col[k]]));
            ar = ar + vr*xr - vi*xi;
            ai = ai + vr*xi + vi*xr;
         end
      end
      return {sat_ref(ar >>> FRAC), sat_ref(ai >>> FRAC)};
   endfunction

   task automatic load_vec(input vec_t v, input int first, input bit chk_rdy, input string tag);
      int w;
      for (int s = first; s < MR; s++) begin
         src_vld = 1'b1;
         src_r   = v.r[s];
         src_i   = v.i[s];
         w = 0;
         @(negedge clk);
         if (chk_rdy) chk(tag, 64'(src_rdy), 64'd1);
         while (!src_rdy && w < 40) begin
            @(negedge clk);
            w++;
         end
         if (!src_rdy) chk({tag, "_timeout"}, 64'(src_rdy), 64'd1);
         @(posedge clk);
         #1;
      end
      src_vld = 1'b0;
      vecq.push_back(v);
   endtask

   task automatic send_row(input row_t r, input logic [63:0] exp);
      int w;
      for (int k = 0; k < NZ; k++) begin
         S_col[k*AW +: AW]   = AW'(r.col[k]);
         S_val_r[k*DW +: DW] = r.vr[k];
         S_val_i[k*DW +: DW] = r.vi[k];
      end
      S_mask = r.mask;
      S_last = r.last;
      S_vld  = 1'b1;
      w = 0;
      @(negedge clk);
      while (!S_rdy && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!S_rdy) chk("row_timeout", 64'(S_rdy), 64'd1);
      @(posedge clk);
      exp_q.push_back(exp);
      if (r.last && vecq.size() > 0) void'(vecq.pop_front());
      #1;
      S_vld = 1'b0;
   endtask

   task automatic drain(input string tag);
      int w;
      w = 0;
      while (obs_q.size() < exp_q.size() && w < 60) begin
         @(posedge clk);
         #1;
         w++;
      end
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0) chk(tag, obs_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout n_pass=%0d n_tot=%0d", n_pass, n_tot);
      $fatal(1);
   end

   initial begin
      vec_t v, va, vb, vc;
      row_t r;
      int   w;

      // reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_src_rdy", 64'(src_rdy), 64'd1);
      chk("rst_S_rdy",   64'(S_rdy),   64'd0);
      chk("rst_vld",     64'(spmv_vld), 64'd0);
      chk("rst_idx_err", 64'(idx_err), 64'd0);
      chk("rst_busy",    64'(busy),    64'd0);
      chk("rst_data",    {spmv_r, spmv_i}, 64'd0);

      // test 1: x[k]=k, sum of cols 1..4, latency
      for (int s = 0; s < MR; s++) begin
         v.r[s] = 32'(s) << 16;
         v.i[s] = '0;
      end
      load_vec(v, 0, 1'b0, "t1_load");
      chk("t1_busy", 64'(busy), 64'd1);
      for (int k = 0; k < NZ; k++) begin
         r.col[k] = k + 1;
         r.vr[k]  = 32'h0001_0000;
         r.vi[k]  = '0;
      end
      r.mask = 4'b1111;
      r.last = 1'b1;
      send_row(r, {32'h000A_0000, 32'h0});
      chk("t1_lat0", 64'(spmv_vld), 64'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("t1_lat12", 64'(spmv_vld), 64'd0);
      end
      @(posedge clk);
      #1;
      chk("t1_lat3", 64'(spmv_vld), 64'd1);
      drain("t1_data");

      // test 2: single complex lane, other lanes masked off
      v = rnd_vec();
      v.r[0] = 32'h0001_0000;
      v.i[0] = 32'h0002_0000;
      load_vec(v, 0, 1'b0, "t2_load");
      r = gen_row(1'b1);
      r.col[0] = 0;
      r.vr[0]  = 32'h0003_0000;
      r.vi[0]  = 32'h0004_0000;
      r.mask   = 4'b0001;
      send_row(r, {32'hFFFB_0000, 32'h000A_0000});
      drain("t2_cplx");

      // test 3: positive and negative saturation
      for (int s = 0; s < MR; s++) begin
         v.r[s] = 32'h7FFF_0000;
         v.i[s] = '0;
      end
      load_vec(v, 0, 1'b0, "t3_load");
      for (int k = 0; k < NZ; k++) begin
         r.col[k] = k;
         r.vr[k]  = 32'h0001_0000;
         r.vi[k]  = '0;
      end
      r.mask = 4'b1111;
      r.last = 1'b0;
      send_row(r, {32'h7FFF_FFFF, 32'h0});
      for (int k = 0; k < NZ; k++) r.vr[k] = 32'hFFFF_0000;
      r.last = 1'b1;
      send_row(r, {32'h8000_0000, 32'h0});
      drain("t3_sat");

      // test 4: six back-to-back rows with a 5-cycle output stall
      load_vec(rnd_vec(), 0, 1'b0, "t4_load");
      for (int j = 0; j < 4; j++) begin
         r = gen_row(1'b0);
         send_row(r, ref_row(r, vecq[0]));
      end
      spmv_rdy = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("t4_stall_S_rdy", 64'(S_rdy), 64'd0);
         chk("t4_stall_vld",   64'(spmv_vld), 64'd1);
         chk("t4_stall_data",  {spmv_r, spmv_i}, exp_q[0]);
         @(posedge clk);
         #1;
      end
      spmv_rdy = 1'b1;
      for (int j = 4; j < 6; j++) begin
         r = gen_row(j == 5);
         send_row(r, ref_row(r, vecq[0]));
      end
      drain("t4_stream");

      // test 5: ping-pong load overlap
      va = rnd_vec();
      vb = rnd_vec();
      vc = rnd_vec();
      load_vec(va, 0, 1'b0, "t5_loadA");
      fork
         begin
            load_vec(vb, 0, 1'b1, "t5_B_src_rdy");
            src_vld = 1'b1;
            src_r   = vc.r[0];
            src_i   = vc.i[0];
            w = 0;
            @(negedge clk);
            while (!a_last_done && w < 40) begin
               chk("t5_C_src_rdy_low", 64'(src_rdy), 64'd0);
               @(negedge clk);
               w++;
            end
            chk("t5_C_src_rdy_rise", 64'(src_rdy), 64'd1);
            @(posedge clk);
            #1;
            load_vec(vc, 1, 1'b0, "t5_loadC");
         end
         begin
            row_t ra;
            for (int j = 0; j < 8; j++) begin
               ra = gen_row(j == 7);
               send_row(ra, ref_row(ra, vecq[0]));
            end
            a_last_done = 1'b1;
         end
      join
      drain("t5_A_rows");
      for (int j = 0; j < 4; j++) begin
         r = gen_row(j == 3);
         send_row(r, ref_row(r, vecq[0]));
      end
      drain("t5_B_rows");

      // test 6: out-of-range column, sticky error, mid-stream reset
      chk("t6_idx_err_pre", 64'(idx_err), 64'd0);
      r = gen_row(1'b0);
      r.col[2] = 7;
      r.mask   = 4'b1111;
      send_row(r, ref_row(r, vecq[0]));
      drain("t6_oor_row");
      chk("t6_idx_err_set", 64'(idx_err), 64'd1);
      r = gen_row(1'b0);
      send_row(r, ref_row(r, vecq[0]));
      drain("t6_next_row");
      chk("t6_idx_err_sticky", 64'(idx_err), 64'd1);
      r = gen_row(1'b0);
      send_row(r, ref_row(r, vecq[0]));
      r = gen_row(1'b0);
      send_row(r, ref_row(r, vecq[0]));
      rst = 1'b1;
      #1;
      chk("t6_rst_vld_async", 64'(spmv_vld), 64'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      exp_q.delete();
      obs_q.delete();
      vecq.delete();
      @(posedge clk);
      #1;
      chk("t6_rst_vld",     64'(spmv_vld), 64'd0);
      chk("t6_rst_idx_err", 64'(idx_err),  64'd0);
      chk("t6_rst_S_rdy",   64'(S_rdy),    64'd0);
      chk("t6_rst_src_rdy", 64'(src_rdy),  64'd1);
      chk("t6_rst_busy",    64'(busy),     64'd0);

      load_vec(rnd_vec(), 0, 1'b0, "post_load");
      for (int j = 0; j < 3; j++) begin
         r = gen_row(j == 2);
         send_row(r, ref_row(r, vecq[0]));
      end
      drain("post_rst_rows");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
